// File: rtl/fetch_queue_pkg.sv
// Shared defaults and constants for the fetch queue.
// Optional empty-queue bypass is selected with FETCH_QUEUE_BYPASS_EN.
package fetch_queue_pkg;

  localparam int FQ_DATA_W = 32;
  localparam int FQ_ADDR_W = 32;
  localparam int FQ_DEPTH  = 4;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  typedef enum logic [1:0] {
    CNT_HOLD = 2'b00,
    CNT_DEC  = 2'b01,
    CNT_INC  = 2'b10,
    CNT_BOTH = 2'b11
  } cnt_op_e;

endpackage

// File: rtl/fq_ptr.sv
// Wrapping queue pointer with clear and increment.
// Natural power-of-two overflow provides the wrap.
module fq_ptr #(
  parameter int PW = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [PW-1:0] ptr_o
);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue between fetch and decode, flushable.
// Define FETCH_QUEUE_BYPASS_EN for 0-cycle empty-queue bypass.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DATA_W = FQ_DATA_W,
  parameter int ADDR_W = FQ_ADDR_W,
  parameter int DEPTH  = FQ_DEPTH,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_valid_i,
  input  logic [DATA_W-1:0] push_inst_i,
  input  logic [ADDR_W-1:0] push_pc_i,
  output logic              push_ready_o,
  output logic              pop_valid_o,
  output logic [DATA_W-1:0] pop_inst_o,
  output logic [ADDR_W-1:0] pop_pc_o,
  input  logic              pop_ready_i,
  input  logic              flush_i,
  output logic [CW-1:0]     count_o
);

  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     count_d;
  logic [DATA_W-1:0] inst_q [DEPTH];
  logic [DATA_W-1:0] inst_d [DEPTH];
  logic [ADDR_W-1:0] pc_q   [DEPTH];
  logic [ADDR_W-1:0] pc_d   [DEPTH];

  logic    empty;
  logic    byp;
  logic    push_acc;
  logic    pop_acc;
  logic    wr_en;
  logic    rd_inc;
  cnt_op_e cnt_op;

  assign empty        = (count_q == '0);
  assign push_ready_o = (count_q != CW'(DEPTH));

`ifdef FETCH_QUEUE_BYPASS_EN
  assign byp = empty && push_valid_i && !flush_i;
`else
  assign byp = 1'b0;
`endif

  assign pop_valid_o = !empty || byp;
  assign push_acc    = push_valid_i && push_ready_o && !flush_i;
  assign pop_acc     = pop_valid_o && pop_ready_i && !flush_i;
  // A bypassed entry consumed the same cycle never touches storage.
  assign wr_en       = push_acc && !(byp && pop_ready_i);
  assign rd_inc      = pop_acc && !byp;
  assign cnt_op      = cnt_op_e'({wr_en, rd_inc});

  always_comb begin
    pop_inst_o = DATA_W'(NOP_INST);
    pop_pc_o   = '0;
    if (byp) begin
      pop_inst_o = push_inst_i;
      pop_pc_o   = push_pc_i;
    end else if (!empty) begin
      pop_inst_o = inst_q[rd_ptr];
      pop_pc_o   = pc_q[rd_ptr];
    end
  end

  always_comb begin
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else begin
      unique case (cnt_op)
        CNT_INC:  count_d = count_q + CW'(1);
        CNT_DEC:  count_d = count_q - CW'(1);
        default:  count_d = count_q;
      endcase
    end
  end

  always_comb begin
    inst_d = inst_q;
    pc_d   = pc_q;
    if (wr_en) begin
      inst_d[wr_ptr] = push_inst_i;
      pc_d[wr_ptr]   = push_pc_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Storage is deliberately left unreset; only occupancy matters.
  always_ff @(posedge clk_i) begin
    inst_q <= inst_d;
    pc_q   <= pc_d;
  end

  fq_ptr #(.PW(PW)) u_rd_ptr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (flush_i),
    .inc_i (rd_inc),
    .ptr_o (rd_ptr)
  );

  fq_ptr #(.PW(PW)) u_wr_ptr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (flush_i),
    .inc_i (wr_en),
    .ptr_o (wr_ptr)
  );

  assign count_o = count_q;

endmodule
